// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: REQ_N valid/ready producers share one FIFO write port, bursts of up to MAX_BURST beats.
// Latency: one arbitration bubble per grant; ready/wren follow i_fifo_full combinationally, so no write is issued while full.
module fifo_wr_arbiter #(
    parameter  int REQ_N        = 4,
    parameter  int DATA_W       = 128,
    parameter  int MAX_BURST    = 8,
    parameter  int USE_ALM_FULL = 1,
    localparam int GID_W        = (REQ_N > 1) ? $clog2(REQ_N) : 1,
    localparam int CNT_W        = $clog2(MAX_BURST + 1)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [REQ_N-1:0]        i_req_valid,
    input  logic [REQ_N*DATA_W-1:0] i_req_data,
    output logic [REQ_N-1:0]        o_req_ready,
    output logic                    o_fifo_wren,
    output logic [DATA_W-1:0]       o_fifo_wrdata,
    input  logic                    i_fifo_full,
    input  logic                    i_fifo_alm_full,
    output logic [GID_W-1:0]        o_grant_id,
    output logic                    o_busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             state_q,    state_d;
    logic [GID_W-1:0]   grant_id_q, grant_id_d;
    logic [GID_W-1:0]   rr_ptr_q,   rr_ptr_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;

    logic               eligible;
    logic               found;
    logic [GID_W-1:0]   winner;
    logic [GID_W-1:0]   cand;
    logic               beat;
    logic [REQ_N-1:0]   ready_vec;

    // Almost-full only gates new grants; an open burst is stopped by full alone.
    assign eligible = (|i_req_valid) && !((USE_ALM_FULL != 0) && i_fifo_alm_full);

    // Scan starts one past the last winner, so a producer just served goes last.
    always_comb begin
        found  = 1'b0;
        winner = rr_ptr_q;
        cand   = '0;
        for (int i = 1; i <= REQ_N; i++) begin
            cand = GID_W'((int'(rr_ptr_q) + i) % REQ_N);
            if (!found && i_req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign beat = (state_q == GRANT) && i_req_valid[grant_id_q] && !i_fifo_full;

    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (eligible) begin
                    state_d    = GRANT;
                    grant_id_d = winner;
                    rr_ptr_d   = winner;
                    beat_cnt_d = '0;
                end
            end
            GRANT: begin
                if (!i_req_valid[grant_id_q]) begin
                    state_d = IDLE;
                end else if (!i_fifo_full) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    if (beat_cnt_q == CNT_W'(MAX_BURST - 1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            grant_id_q <= '0;
            rr_ptr_q   <= GID_W'(REQ_N - 1);
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    always_comb begin
        ready_vec = '0;
        if (state_q == GRANT && !i_fifo_full) begin
            ready_vec[grant_id_q] = 1'b1;
        end
    end

    assign o_req_ready   = ready_vec;
    assign o_fifo_wren   = beat;
    assign o_fifo_wrdata = i_req_data[int'(grant_id_q)*DATA_W +: DATA_W];
    assign o_grant_id    = grant_id_q;
    assign o_busy        = (state_q == GRANT);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: vector table, directed corner sequences, then random traffic against a reference model.
module tb_fifo_wr_arbiter;

    localparam int REQ_N     = 4;
    localparam int DATA_W    = 128;
    localparam int MAX_BURST = 8;

    logic                    clk = 1'b0;
    logic                    rstn;
    logic [REQ_N-1:0]        i_req_valid;
    logic [REQ_N*DATA_W-1:0] i_req_data;
    logic [REQ_N-1:0]        o_req_ready;
    logic                    o_fifo_wren;
    logic [DATA_W-1:0]       o_fifo_wrdata;
    logic                    i_fifo_full;
    logic                    i_fifo_alm_full;
    logic [1:0]              o_grant_id;
    logic                    o_busy;

    int checks = 0;
    int errors = 0;

    fifo_wr_arbiter #(
        .REQ_N(REQ_N), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST), .USE_ALM_FULL(1)
    ) dut (
        .clk(clk), .rstn(rstn),
        .i_req_valid(i_req_valid), .i_req_data(i_req_data),
        .o_req_ready(o_req_ready), .o_fifo_wren(o_fifo_wren),
        .o_fifo_wrdata(o_fifo_wrdata), .i_fifo_full(i_fifo_full),
        .i_fifo_alm_full(i_fifo_alm_full), .o_grant_id(o_grant_id),
        .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] vld;
        logic       full;
        logic       alm;
        logic       wren;
        logic [3:0] rdy;
        logic       busy;
        int         gid;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic chkd(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] mk(input int p, input int s);
        logic [DATA_W-1:0] d;
        d = '0;
        d[127:96] = 32'hFEED_0000;
        d[31:24]  = 8'(p);
        d[23:0]   = 24'(s);
        return d;
    endfunction

    // Asynchronous reset pulse placed mid-cycle, well away from any clock edge.
    task automatic do_reset();
        @(posedge clk); #1;
        i_req_valid = '0; i_fifo_full = 1'b0; i_fifo_alm_full = 1'b0;
        rstn = 1'b0;
        #1;
        rstn = 1'b1;
    endtask

    // Reference model: who owns the port, who was served last, beats taken in this grant.
    bit m_busy;
    int m_owner, m_last, m_beats;

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_last = REQ_N - 1; m_beats = 0;
    endtask

    task automatic model_step(input logic [3:0] v, input logic f, input logic a);
        int best, bestd, d;
        if (!m_busy) begin
            if (v != 0 && !a) begin
                best = 0; bestd = REQ_N;
                for (int k = 0; k < REQ_N; k++) begin
                    d = (k - m_last - 1 + 2 * REQ_N) % REQ_N;
                    if (v[k] && d < bestd) begin best = k; bestd = d; end
                end
                m_owner = best; m_last = best; m_beats = 0; m_busy = 1;
            end
        end else if (!v[m_owner]) begin
            m_busy = 0;
        end else if (!f) begin
            m_beats++;
            if (m_beats == MAX_BURST) m_busy = 0;
        end
    endtask

    initial begin
        int seq[REQ_N];
        int exp_seq[REQ_N];
        int blen[8];
        int order[5];
        int writes, stalls, bursts, cur;
        bit prev_busy;
        logic [3:0] v;
        logic f, a;
        logic [DATA_W-1:0] exp_d;

        tbl[0] = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 0};
        tbl[1] = '{4'b0010, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 0};
        tbl[2] = '{4'b0010, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 0};
        tbl[3] = '{4'b0010, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 0};
        tbl[4] = '{4'b0010, 1'b0, 1'b0, 1'b1, 4'b0010, 1'b1, 1};
        tbl[5] = '{4'b0010, 1'b0, 1'b1, 1'b1, 4'b0010, 1'b1, 1};
        tbl[6] = '{4'b0010, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1};
        tbl[7] = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b1, 1};
        tbl[8] = '{4'b0001, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1};
        tbl[9] = '{4'b0001, 1'b0, 1'b0, 1'b1, 4'b0001, 1'b1, 0};
        order = '{0, 1, 2, 3, 0};

        rstn = 1'b0; i_req_valid = '0; i_fifo_full = 1'b0; i_fifo_alm_full = 1'b0;
        i_req_data = '0;
        for (int p = 0; p < REQ_N; p++) i_req_data[p*DATA_W +: DATA_W] = mk(p, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", int'(o_busy), 0);
        chk("reset_wren", int'(o_fifo_wren), 0);
        chk("reset_ready", int'(o_req_ready), 0);
        chk("reset_gid", int'(o_grant_id), 0);
        rstn = 1'b1;

        // Vector table: alm-full gating, stall, early drop, rr_ptr wrap.
        for (int r = 0; r < 10; r++) begin
            @(posedge clk); #1;
            i_req_valid = tbl[r].vld; i_fifo_full = tbl[r].full; i_fifo_alm_full = tbl[r].alm;
            #1;
            chk($sformatf("tbl%0d_wren", r), int'(o_fifo_wren), int'(tbl[r].wren));
            chk($sformatf("tbl%0d_ready", r), int'(o_req_ready), int'(tbl[r].rdy));
            chk($sformatf("tbl%0d_busy", r), int'(o_busy), int'(tbl[r].busy));
            chk($sformatf("tbl%0d_gid", r), int'(o_grant_id), tbl[r].gid);
            chkd($sformatf("tbl%0d_data", r), o_fifo_wrdata, mk(tbl[r].gid, 0));
        end

        // Reset in the middle of a beat: outputs must drop with no clock edge.
        #1;
        chk("pre_rst_wren", int'(o_fifo_wren), 1);
        rstn = 1'b0;
        #1;
        chk("midrst_wren", int'(o_fifo_wren), 0);
        chk("midrst_ready", int'(o_req_ready), 0);
        chk("midrst_busy", int'(o_busy), 0);
        rstn = 1'b1;
        i_req_valid = 4'b1111;
        @(posedge clk); #1;
        chk("post_rst_busy", int'(o_busy), 1);
        chk("post_rst_gid", int'(o_grant_id), 0);

        // Single producer 2 streaming: 8 beats, 1 bubble, 8 beats, in order.
        do_reset();
        seq[2] = 0; exp_seq[2] = 0;
        for (int c = 0; c < 19; c++) begin
            @(posedge clk); #1;
            i_req_valid = 4'b0100;
            i_req_data[2*DATA_W +: DATA_W] = mk(2, seq[2]);
            #1;
            chk($sformatf("single_wren_c%0d", c), int'(o_fifo_wren), (c % 9 == 0) ? 0 : 1);
            if (c >= 1) chk($sformatf("single_gid_c%0d", c), int'(o_grant_id), 2);
            if (o_fifo_wren) begin
                chkd($sformatf("single_data_c%0d", c), o_fifo_wrdata, mk(2, exp_seq[2]));
                exp_seq[2]++;
            end
            if (o_req_ready[2]) seq[2]++;
        end

        // All producers valid: rotation 0,1,2,3,0 with a 3-cycle full stall at beat 4.
        do_reset();
        for (int p = 0; p < REQ_N; p++) begin seq[p] = 0; exp_seq[p] = 0; end
        for (int b = 0; b < 8; b++) blen[b] = 0;
        writes = 0; stalls = 0; bursts = 0; cur = 0; prev_busy = 0;
        for (int c = 0; c < 49; c++) begin
            @(posedge clk); #1;
            i_req_valid = 4'b1111;
            i_fifo_full = (writes == 3 && stalls < 3);
            for (int p = 0; p < REQ_N; p++) i_req_data[p*DATA_W +: DATA_W] = mk(p, seq[p]);
            #1;
            if (i_fifo_full) begin
                stalls++;
                chk($sformatf("stall%0d_wren", stalls), int'(o_fifo_wren), 0);
                chk($sformatf("stall%0d_ready", stalls), int'(o_req_ready), 0);
            end
            if (o_busy && !prev_busy) begin
                if (bursts < 5) begin
                    cur = order[bursts];
                    chk($sformatf("rr_grant%0d", bursts), int'(o_grant_id), cur);
                end
                bursts++;
            end
            prev_busy = o_busy;
            if (o_fifo_wren && bursts >= 1 && bursts <= 8) begin
                chkd($sformatf("rr_data_b%0d", bursts - 1), o_fifo_wrdata, mk(cur, exp_seq[cur]));
                exp_seq[cur]++;
                blen[bursts-1]++;
                writes++;
            end
            for (int p = 0; p < REQ_N; p++) if (o_req_ready[p] && i_req_valid[p]) seq[p]++;
        end
        chk("rr_bursts", bursts, 5);
        for (int b = 0; b < 5; b++) chk($sformatf("rr_len%0d", b), blen[b], MAX_BURST);
        chk("rr_stalls", stalls, 3);
        i_fifo_full = 1'b0;

        // Early release by producer 3 after 2 beats; next grant wraps to 0.
        do_reset();
        @(posedge clk); #1; i_req_valid = 4'b1000;
        @(posedge clk); #1; i_req_valid = 4'b1001; #1;
        chk("early_b1_gid", int'(o_grant_id), 3);
        chk("early_b1_wren", int'(o_fifo_wren), 1);
        @(posedge clk); #2;
        chk("early_b2_wren", int'(o_fifo_wren), 1);
        @(posedge clk); #1; i_req_valid = 4'b0001; #1;
        chk("early_drop_wren", int'(o_fifo_wren), 0);
        chk("early_drop_busy", int'(o_busy), 1);
        @(posedge clk); #2;
        chk("early_idle_busy", int'(o_busy), 0);
        @(posedge clk); #2;
        chk("early_next_gid", int'(o_grant_id), 0);
        chk("early_next_wren", int'(o_fifo_wren), 1);

        // Random traffic against the reference model.
        do_reset();
        model_reset();
        v = '0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            for (int p = 0; p < REQ_N; p++) begin
                if ($urandom_range(7) == 0) v[p] = ~v[p];
                i_req_data[p*DATA_W +: DATA_W] = {$urandom, $urandom, $urandom, $urandom};
            end
            f = ($urandom_range(3) == 0);
            a = ($urandom_range(3) == 0);
            i_req_valid = v; i_fifo_full = f; i_fifo_alm_full = a;
            #1;
            exp_d = i_req_data[m_owner*DATA_W +: DATA_W];
            chk($sformatf("rnd%0d_busy", c), int'(o_busy), int'(m_busy));
            chk($sformatf("rnd%0d_gid", c), int'(o_grant_id), m_owner);
            chk($sformatf("rnd%0d_wren", c), int'(o_fifo_wren), int'(m_busy && v[m_owner] && !f));
            chk($sformatf("rnd%0d_ready", c), int'(o_req_ready), (m_busy && !f) ? (1 << m_owner) : 0);
            chkd($sformatf("rnd%0d_data", c), o_fifo_wrdata, exp_d);
            model_step(v, f, a);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares the write port of the 128-bit FIFO among REQ_N producers. Each producer presents data on a valid/ready handshake. The arbiter grants one producer at a time for a burst of up to MAX_BURST beats and drives the FIFO's write enable and write data. It sits directly in front of the FIFO write port. It honours full and, optionally, almost-full back-pressure.

## Interface
- REQ_N, 4, number of producers (2..16)
- DATA_W, 128, data width; matches FIFO write data
- MAX_BURST, 8, max beats per grant (1..255)
- USE_ALM_FULL, 1, when 1 no new grant is issued while FIFO almost-full is high
- clk  in  1  clock; all state on rising edge
- rstn  in  1  asynchronous, active-low reset
- i_req_valid  in  REQ_N  per-producer valid
- i_req_data  in  REQ_N*DATA_W  producer k data at bits [k*DATA_W +: DATA_W]
- o_req_ready  out  REQ_N  per-producer ready; at most one bit high
- o_fifo_wren  out  1  FIFO write enable
- o_fifo_wrdata  out  DATA_W  FIFO write data
- i_fifo_full  in  1  FIFO full
- i_fifo_alm_full  in  1  FIFO almost full
- o_grant_id  out  max(1,$clog2(REQ_N))  index of the current/last granted producer
- o_busy  out  1  high in GRANT state

## Operation
- States: IDLE, GRANT.
- Registers: state, grant_id, rr_ptr (last granted index), beat_cnt ($clog2(MAX_BURST+1) bits).
- IDLE behaviour:
  - Eligible = any i_req_valid AND NOT (USE_ALM_FULL AND i_fifo_alm_full).
  - If eligible, pick the first valid index scanning rr_ptr+1, rr_ptr+2, … modulo REQ_N.
  - On the next edge: grant_id ← winner, rr_ptr ← winner, beat_cnt ← 0, state ← GRANT.
  - No data transfers in IDLE. This is a 1-cycle arbitration bubble per grant.
- GRANT behaviour:
  - Beat = i_req_valid[grant_id] AND NOT i_fifo_full.
  - On a beat: beat_cnt increments.
  - Exit to IDLE on the same edge when the beat makes beat_cnt reach MAX_BURST.
  - If i_req_valid[grant_id] = 0: state ← IDLE. No beat, burst ends early.
  - If i_fifo_full = 1 with valid high: stall, hold state and beat_cnt.
  - i_fifo_alm_full does not interrupt a burst in progress. The FIFO's own full is the only stall.
- Combinational outputs (GRANT only; all 0 in IDLE):
  - o_req_ready[grant_id] = NOT i_fifo_full.
  - o_fifo_wren = beat.
  - o_fifo_wrdata = i_req_data slice of grant_id; holds that slice in IDLE as well.
- o_busy = (state == GRANT). o_grant_id = grant_id register.
- Producers must hold data stable while valid is high and ready is low.

## Timing
- Reset (async assert, sync release edge irrelevant):
  - state = IDLE, grant_id = 0, rr_ptr = REQ_N-1 (producer 0 wins first), beat_cnt = 0.
  - o_req_ready = 0, o_fifo_wren = 0, o_busy = 0, o_grant_id = 0.
- Reset mid-burst: all outputs drop immediately. The partial burst is abandoned; beats already written stay in the FIFO.
- Latency: valid rising in IDLE gives the first beat on the 2nd edge (grant edge, then transfer edge).
- Sustained throughput for a continuously valid single producer: MAX_BURST beats per MAX_BURST+1 cycles.
- Full/ready paths are combinational: i_fifo_full → o_req_ready/o_fifo_wren in the same cycle. A write is never issued while i_fifo_full = 1.
- Simultaneous valid on all producers: grants rotate 0,1,2,…,REQ_N-1,0.
- A producer that deasserts valid loses its grant. It re-arbitrates through rr_ptr and does not get priority again until others are served.
- rr_ptr wrap-around: REQ_N-1 → 0.

## Test plan
- Reset/idle:
  - Assert rstn = 0 mid-GRANT with o_fifo_wren = 1 → o_fifo_wren, o_req_ready, o_busy go 0 without a clock edge.
  - After release, all valid → first grant_id = 0.
- Single producer: producer 2 continuously valid, MAX_BURST = 8, FIFO never full → 8 writes, 1 idle cycle, 8 writes. Data written in order, o_grant_id = 2 throughout.
- Round-robin: all 4 producers valid, each with distinct tagged data → grant order 0,1,2,3,0. Exactly 8 beats each, no beat duplicated or lost.
- Full back-pressure:
  - Raise i_fifo_full for 3 cycles at beat 4 of a burst → o_fifo_wren and o_req_ready low those 3 cycles.
  - beat_cnt frozen; burst resumes and ends after beat 8 (8 writes total).
- Almost-full gating with USE_ALM_FULL = 1:
  - i_fifo_alm_full high in IDLE with producer 1 valid → no grant while high; grant issues 1 edge after it drops.
  - i_fifo_alm_full rising mid-burst → burst completes all 8 beats.
- Early release: producer 3 drops valid after 2 beats while producer 0 valid → GRANT→IDLE with no write that cycle; next grant to producer 0 (scan from rr_ptr = 3 wraps to 0).
